hazard_scoreboard: RTL and testbench

Tracks the destination-register tags of every in-flight instruction in the EX, MEMPREP, MEMEX and WB stages, and stalls ID whenever a source operand cannot be forwarded. It is the producer-side companion to operand forwarding: it owns the per-stage write-enable, rd and rd_data_sel tags that forwarding consumes, and it inserts bubbles for load-use and link-use hazards. It also counts stall cycles for performance monitoring.

---
 rtl/pipeline_pkg.sv | 36 +++
 rtl/scoreboard_tag_stage.sv | 26 ++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared scoreboard tag type, writeback-select codes and forwarding rule
package pipeline_pkg;

  localparam logic [1:0] RD_DATA_SEL_ALU  = 2'b00;
  localparam logic [1:0] RD_DATA_SEL_MEM  = 2'b01;
  localparam logic [1:0] RD_DATA_SEL_PC4  = 2'b10;
  localparam logic [1:0] RD_DATA_SEL_RSVD = 2'b11;

  localparam int NUM_STAGES = 4;
  localparam logic [1:0] STAGE_EX      = 2'd0;
  localparam logic [1:0] STAGE_MEMPREP = 2'd1;
  localparam logic [1:0] STAGE_MEMEX   = 2'd2;
  localparam logic [1:0] STAGE_WB      = 2'd3;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [3:0] rd;
    logic [1:0] sel;
  } scoreboard_tag_t;

  localparam int TAG_W = $bits(scoreboard_tag_t);

  // PC4 is produced late in EX, so it can only be forwarded once it reaches MEMPREP.
  function automatic logic fwd_ok(input logic [1:0] stage_idx, input logic [1:0] sel);
    logic ok;
    ok = 1'b0;
    case (sel)
      RD_DATA_SEL_ALU: ok = 1'b1;
      RD_DATA_SEL_PC4: ok = (stage_idx != STAGE_EX);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/scoreboard_tag_stage.sv
// rtl/scoreboard_tag_stage.sv - one pipeline tag register with hold, bubble and load controls
module scoreboard_tag_stage
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             bubble,
  input  logic             load,
  input  logic [TAG_W-1:0] d,
  output logic [TAG_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      if (bubble) begin
        q <= '0;
      end else if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight rd tag tracking, ID stall generation and stall-cycle counter
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_ID,
  input  logic                   regfile_we_ID,
  input  logic [3:0]             rd_ID,
  input  logic [1:0]             rd_data_sel_ID,
  input  logic [3:0]             rs1,
  input  logic [3:0]             rs2,
  input  logic                   uses_rs1,
  input  logic                   uses_rs2,
  input  logic                   flush_EX,
  input  logic                   mem_stall,
  input  logic                   perf_clear,
  output logic                   regfile_we_EX,
  output logic                   regfile_we_MEMPREP,
  output logic                   regfile_we_MEMEX,
  output logic                   regfile_we_WB,
  output logic [3:0]             rd_EX,
  output logic [3:0]             rd_MEMPREP,
  output logic [3:0]             rd_MEMEX,
  output logic [3:0]             rd_WB,
  output logic [1:0]             rd_data_sel_EX,
  output logic [1:0]             rd_data_sel_MEMPREP,
  output logic [1:0]             rd_data_sel_MEMEX,
  output logic [1:0]             rd_data_sel_WB,
  output logic                   stall_ID,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [TAG_W-1:0] tag_q [NUM_STAGES];
  scoreboard_tag_t  tags  [NUM_STAGES];
  scoreboard_tag_t  tag_id;
  logic             accept_id;

  // x0 is stored as a non-writer so it can never match a consumer.
  always_comb begin
    tag_id.valid = valid_ID;
    tag_id.we    = regfile_we_ID & (rd_ID != 4'd0);
    tag_id.rd    = rd_ID;
    tag_id.sel   = rd_data_sel_ID;
  end

  assign accept_id = valid_ID & ~stall_ID & ~flush_EX;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_ex
      scoreboard_tag_stage u_stage (
        .clk    (clk),
        .rst    (rst),
        .hold   (mem_stall),
        .bubble (~accept_id),
        .load   (accept_id),
        .d      (tag_id),
        .q      (tag_q[i])
      );
    end else begin : g_later
      scoreboard_tag_stage u_stage (
        .clk    (clk),
        .rst    (rst),
        .hold   (mem_stall),
        .bubble (1'b0),
        .load   (1'b1),
        .d      (tag_q[i-1]),
        .q      (tag_q[i])
      );
    end
    assign tags[i] = tag_q[i];
  end

  // Walk from oldest to youngest so the youngest matching stage decides.
  logic haz1;
  logic haz2;
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (tags[i].valid && tags[i].we && tags[i].rd == rs1) begin
        haz1 = ~fwd_ok(2'(i), tags[i].sel);
      end
      if (tags[i].valid && tags[i].we && tags[i].rd == rs2) begin
        haz2 = ~fwd_ok(2'(i), tags[i].sel);
      end
    end
  end

  assign stall_ID = valid_ID &
                    ((uses_rs1 & (rs1 != 4'd0) & haz1) |
                     (uses_rs2 & (rs2 != 4'd0) & haz2));

  always_ff @(posedge clk) begin
    if (rst || perf_clear) begin
      stall_count <= '0;
    end else if (stall_ID && !mem_stall) begin
      stall_count <= stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign regfile_we_EX       = tags[0].we & tags[0].valid;
  assign regfile_we_MEMPREP  = tags[1].we & tags[1].valid;
  assign regfile_we_MEMEX    = tags[2].we & tags[2].valid;
  assign regfile_we_WB       = tags[3].we & tags[3].valid;
  assign rd_EX               = tags[0].rd;
  assign rd_MEMPREP          = tags[1].rd;
  assign rd_MEMEX            = tags[2].rd;
  assign rd_WB               = tags[3].rd;
  assign rd_data_sel_EX      = tags[0].sel;
  assign rd_data_sel_MEMPREP = tags[1].sel;
  assign rd_data_sel_MEMEX   = tags[2].sel;
  assign rd_data_sel_WB      = tags[3].sel;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;
  import pipeline_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, valid_ID, regfile_we_ID, uses_rs1, uses_rs2, flush_EX, mem_stall, perf_clear;
  logic [3:0] rd_ID, rs1, rs2;
  logic [1:0] rd_data_sel_ID;
  logic regfile_we_EX, regfile_we_MEMPREP, regfile_we_MEMEX, regfile_we_WB, stall_ID;
  logic [3:0] rd_EX, rd_MEMPREP, rd_MEMEX, rd_WB;
  logic [1:0] rd_data_sel_EX, rd_data_sel_MEMPREP, rd_data_sel_MEMEX, rd_data_sel_WB;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_ID(valid_ID), .regfile_we_ID(regfile_we_ID),
    .rd_ID(rd_ID), .rd_data_sel_ID(rd_data_sel_ID), .rs1(rs1), .rs2(rs2),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .flush_EX(flush_EX),
    .mem_stall(mem_stall), .perf_clear(perf_clear),
    .regfile_we_EX(regfile_we_EX), .regfile_we_MEMPREP(regfile_we_MEMPREP),
    .regfile_we_MEMEX(regfile_we_MEMEX), .regfile_we_WB(regfile_we_WB),
    .rd_EX(rd_EX), .rd_MEMPREP(rd_MEMPREP), .rd_MEMEX(rd_MEMEX), .rd_WB(rd_WB),
    .rd_data_sel_EX(rd_data_sel_EX), .rd_data_sel_MEMPREP(rd_data_sel_MEMPREP),
    .rd_data_sel_MEMEX(rd_data_sel_MEMEX), .rd_data_sel_WB(rd_data_sel_WB),
    .stall_ID(stall_ID), .stall_count(stall_count)
  );

  typedef struct {
    string nm;
    logic  st;
    int    cnt;
    int    web;
    bit    zc;
  } exp_t;

  exp_t exp_q[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.nm, ".stall_ID"}, int'(stall_ID), int'(e.st));
      if (e.cnt >= 0) chk({e.nm, ".stall_count"}, int'(stall_count), e.cnt);
      if (e.web >= 0)
        chk({e.nm, ".we_tags"},
            int'({regfile_we_WB, regfile_we_MEMEX, regfile_we_MEMPREP, regfile_we_EX}), e.web);
      if (e.zc)
        chk({e.nm, ".rd_sel_tags"},
            int'({rd_EX, rd_MEMPREP, rd_MEMEX, rd_WB, rd_data_sel_EX, rd_data_sel_MEMPREP,
                  rd_data_sel_MEMEX, rd_data_sel_WB}), 0);
    end
  end

  task automatic id_in(input logic v, input logic we, input logic [3:0] rd, input logic [1:0] sel,
                       input logic [3:0] r1, input logic u1, input logic [3:0] r2, input logic u2);
    valid_ID = v; regfile_we_ID = we; rd_ID = rd; rd_data_sel_ID = sel;
    rs1 = r1; uses_rs1 = u1; rs2 = r2; uses_rs2 = u2;
  endtask

  task automatic idle();          id_in(0, 0, 0, RD_DATA_SEL_ALU, 0, 0, 0, 0); endtask
  task automatic load_x5();       id_in(1, 1, 5, RD_DATA_SEL_MEM, 0, 0, 0, 0); endtask
  task automatic addi_x5();       id_in(1, 1, 5, RD_DATA_SEL_ALU, 0, 0, 0, 0); endtask
  task automatic add_x6_x5_x1();  id_in(1, 1, 6, RD_DATA_SEL_ALU, 5, 1, 1, 1); endtask

  task automatic tick(input string nm, input logic st, input int cnt, input int web, input bit zc);
    exp_t e;
    e.nm = nm; e.st = st; e.cnt = cnt; e.web = web; e.zc = zc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    flush_EX = 0; perf_clear = 0; rst = 0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 4; i++) tick("drain", 0, -1, -1, 0);
  endtask

  initial begin
    rst = 1; flush_EX = 0; mem_stall = 0; perf_clear = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    tick("reset", 0, 0, 0, 1);

    // Load-use: four stall cycles while the load walks EX..WB, then tag latency.
    load_x5();      tick("lu.load", 0, 0, 'b0000, 0);
    add_x6_x5_x1(); tick("lu.ex", 1, 0, 'b0001, 0);
                    tick("lu.memprep", 1, 1, 'b0010, 0);
                    tick("lu.memex", 1, 2, 'b0100, 0);
                    tick("lu.wb", 1, 3, 'b1000, 0);
                    tick("lu.issue", 0, 4, 'b0000, 0);
    idle();         tick("lat.ex", 0, 4, 'b0001, 0);
                    tick("lat.memprep", 0, 4, 'b0010, 0);
                    tick("lat.memex", 0, 4, 'b0100, 0);
                    tick("lat.wb", 0, 4, 'b1000, 0);
                    tick("lat.gone", 0, 4, 'b0000, 0);

    // Link-use: one stall with PC4 in EX; ALU producer forwards without stall.
    perf_clear = 1; tick("pclr1", 0, 4, -1, 0);
    id_in(1, 1, 1, RD_DATA_SEL_PC4, 0, 0, 0, 0); tick("jal", 0, 0, 'b0000, 0);
    id_in(1, 1, 7, RD_DATA_SEL_ALU, 1, 1, 0, 0); tick("link.ex", 1, 0, 'b0001, 0);
                                                  tick("link.memprep", 0, 1, 'b0010, 0);
    id_in(1, 1, 1, RD_DATA_SEL_ALU, 0, 0, 0, 0); tick("alu.prod", 0, 1, 'b0101, 0);
    id_in(1, 1, 7, RD_DATA_SEL_ALU, 1, 1, 0, 0); tick("alu.use", 0, 1, 'b1011, 0);
    drain();

    // x0 producer never stalls and is stored without write-enable.
    id_in(1, 1, 0, RD_DATA_SEL_MEM, 0, 0, 0, 0); tick("x0.prod", 0, 1, 'b0000, 0);
    id_in(1, 1, 7, RD_DATA_SEL_ALU, 0, 1, 0, 1); tick("x0.use", 0, 1, 'b0000, 0);
    drain();

    // Youngest match wins in both orders.
    load_x5();  tick("yw.load", 0, 1, 'b0000, 0);
    addi_x5();  tick("yw.addi", 0, 1, 'b0001, 0);
    id_in(1, 1, 6, RD_DATA_SEL_ALU, 5, 1, 0, 0); tick("yw.use_alu", 0, 1, 'b0011, 0);
    drain();
    addi_x5();  tick("yr.addi", 0, 1, 'b0000, 0);
    load_x5();  tick("yr.load", 0, 1, 'b0001, 0);
    id_in(1, 1, 6, RD_DATA_SEL_ALU, 5, 1, 0, 0);
    tick("yr.s1", 1, 1, 'b0011, 0);
    tick("yr.s2", 1, 2, 'b0110, 0);
    tick("yr.s3", 1, 3, 'b1100, 0);
    tick("yr.s4", 1, 4, 'b1000, 0);
    tick("yr.go", 0, 5, 'b0000, 0);
    drain();

    // mem_stall freezes tags and the counter but extends the stall.
    idle(); perf_clear = 1; tick("pclr2", 0, 5, -1, 0);
    load_x5();      tick("ms.load", 0, 0, 'b0000, 0);
    add_x6_x5_x1(); tick("ms.c1", 1, 0, 'b0001, 0);
    mem_stall = 1;  tick("ms.c2", 1, 1, 'b0010, 0);
                    tick("ms.c3", 1, 1, 'b0010, 0);
                    tick("ms.c4", 1, 1, 'b0010, 0);
    mem_stall = 0;  tick("ms.c5", 1, 1, 'b0010, 0);
                    tick("ms.c6", 1, 2, 'b0100, 0);
                    tick("ms.c7", 1, 3, 'b1000, 0);
                    tick("ms.c8", 0, 4, 'b0000, 0);
    drain();

    // flush_EX squashes the instruction entering EX.
    id_in(1, 1, 3, RD_DATA_SEL_ALU, 0, 0, 0, 0); flush_EX = 1; tick("flush", 0, 4, 'b0000, 0);
    idle(); tick("flush.after", 0, 4, 'b0000, 0);

    // Reset with a load in MEMEX and a stall pending.
    load_x5();      tick("rr.load", 0, 4, 'b0000, 0);
    add_x6_x5_x1(); tick("rr.c1", 1, 4, 'b0001, 0);
                    tick("rr.c2", 1, 5, 'b0010, 0);
    rst = 1;        tick("rr.c3", 1, 6, 'b0100, 0);
                    tick("rr.after", 0, 0, 'b0000, 1);

    // Counter wrap: 16 stall cycles in a 4-bit counter.
    for (int k = 0; k < 4; k++) begin
      load_x5(); tick("wrap.load", 0, (4 * k) % 16, -1, 0);
      add_x6_x5_x1();
      for (int j = 0; j < 4; j++) tick("wrap.stall", 1, (4 * k + j) % 16, -1, 0);
      tick("wrap.go", 0, (4 * k + 4) % 16, -1, 0);
    end

    // perf_clear beats a simultaneous increment.
    load_x5();      tick("cw.load", 0, 0, -1, 0);
    add_x6_x5_x1(); perf_clear = 1; tick("cw.s1", 1, 0, -1, 0);
                    tick("cw.s2", 1, 0, -1, 0);
                    tick("cw.s3", 1, 1, -1, 0);
                    tick("cw.s4", 1, 2, -1, 0);
                    tick("cw.go", 0, 3, -1, 0);
    idle();

    for (int t = 0; t < 4 && exp_q.size() > 0; t++) @(negedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
